// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit-period calculation
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  function automatic int uart_cycle(input int clk_mhz, input int baud);
    return clk_mhz * 1000000 / baud;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  always_ff @(posedge clk) sync_q <= rst ? 2'b11 : {sync_q[0], d};
  assign q = sync_q[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART frame receiver with optional parity and parity/frame error pulses
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FRE     = 100,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int BAUD_RATE   = 9600
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst,
  input  logic                  i_uart_rx,
  output logic [DATA_WIDTH-1:0] o_data_rx,
  output logic                  o_data_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_busy
);
  localparam int CYCLE = uart_cycle(CLK_FRE, BAUD_RATE);
  localparam int CW = $clog2(CYCLE + 1);
  localparam logic [CW-1:0] SAMPLE = CW'(CYCLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLE - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic par_q, par_d, prev_q, disarm_q, disarm_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic rx_s, sample, wrap, exp_par;
  uart_rx_sync u_sync (.clk(i_clk_sys), .rst(i_rst), .d(i_uart_rx), .q(rx_s));
  assign sample = cnt_q == SAMPLE;
  assign wrap = cnt_q == LAST;
  assign exp_par = (PARITY_TYPE != 0) ? ^shift_q : ~^shift_q;
  always_comb begin
    state_d = state_q;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    disarm_d = disarm_q;
    data_d = data_q;
    valid_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        disarm_d = disarm_q & ~rx_s;
        if (!disarm_q && prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (sample && rx_s) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (wrap) begin
          state_d = DATA;
          bit_d = '0;
        end
      end
      DATA: begin
        if (sample) shift_d = (shift_q >> 1) | (DATA_WIDTH'(rx_s) << (DATA_WIDTH - 1));
        if (wrap) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = (PARITY_ON != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample) par_d = rx_s;
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          cnt_d = '0;
          data_d = shift_q;
          valid_d = 1'b1;
          perr_d = (PARITY_ON != 0) && (par_q != exp_par);
          ferr_d = ~rx_s;
          disarm_d = ~rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      prev_q <= 1'b1;
      disarm_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      prev_q <= rx_s;
      disarm_q <= disarm_d;
      data_q <= data_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end
  assign o_data_rx = data_q;
  assign o_data_valid = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err = ferr_q;
  assign o_busy = state_q != IDLE;
endmodule
